// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between several byte-stream sources.
// A grant lasts for a whole message (terminated by req_last). An owner that
// stops presenting bytes mid-message is released by an idle timeout.
module uart_tx_arbiter #(
    parameter int  N_REQ          = 4,
    parameter int  DATA_WIDTH     = 8,
    parameter int  TIMEOUT_CYCLES = 5_000_000,
    localparam int ID_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]       tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy,
    output logic                        timeout
);

    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_IDX  = ID_W'(N_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_reg;
    logic [ID_W-1:0]        owner_reg;
    logic [ID_W-1:0]        rr_ptr_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   busy_reg;
    logic                   timeout_reg;

    logic [DATA_WIDTH-1:0]  lane [N_REQ];
    logic                   owner_valid;
    logic                   owner_last;
    logic                   handshake;
    logic [ID_W-1:0]        next_ptr;
    logic                   pick_found;
    logic [ID_W-1:0]        pick_idx;
    logic [ID_W:0]          cand;

    // Split the flat data bus into lanes and steer ready to the owner only.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign lane[gi]      = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = busy_reg && (owner_reg == ID_W'(gi))
                                   && tx_ready && req_valid[gi];
        end
    endgenerate

    assign owner_valid = req_valid[owner_reg];
    assign owner_last  = req_last[owner_reg];
    assign handshake   = busy_reg && owner_valid && tx_ready;
    assign next_ptr    = (owner_reg == LAST_IDX) ? '0 : owner_reg + ID_W'(1);

    // Data path is a pure passthrough from the owner while a message is open.
    assign tx_valid = busy_reg && owner_valid;
    assign tx_data  = busy_reg ? lane[owner_reg] : '0;
    assign grant_id = owner_reg;
    assign busy     = busy_reg;
    assign timeout  = timeout_reg;

    // First asserted request searching upward from rr_ptr, wrapping at N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!pick_found && req_valid[cand[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Grant FSM with idle-timeout counter; a handshake always beats the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            owner_reg   <= '0;
            rr_ptr_reg  <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg <= GRANT;
                        busy_reg  <= 1'b1;
                        owner_reg <= pick_idx;
                        cnt_reg   <= '0;
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        cnt_reg <= '0;
                        if (owner_last) begin
                            state_reg  <= IDLE;
                            busy_reg   <= 1'b0;
                            rr_ptr_reg <= next_ptr;
                        end
                    end else if (!owner_valid) begin
                        if (cnt_reg >= CNT_LIMIT) begin
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                            rr_ptr_reg  <= next_ptr;
                            timeout_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: N_REQ=4, 8-bit bytes, 16-cycle timeout.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout;

    uart_tx_arbiter #(
        .N_REQ          (4),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;
    int ready_period = 0;
    int to_cnt = 0;
    int to_edge = -1;
    int stray = 0;

    // Per-requester pending bytes: {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [8:0] q3[$];

    // Wire log: byte, owner, edge index relative to base
    logic [7:0] wire_q[$];
    logic [1:0] gid_q[$];
    int         edge_q[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [8:0] qhead(int i);
        if (qsize(i) == 0) return 9'h000;
        case (i)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic push(int i, logic [7:0] d, logic l);
        case (i)
            0: q0.push_back({l, d});
            1: q1.push_back({l, d});
            2: q2.push_back({l, d});
            default: q3.push_back({l, d});
        endcase
    endtask

    task automatic qpop(int i);
        case (i)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic drive();
        logic [8:0] h;
        tx_ready = (ready_period == 0) ? 1'b1 : ((cyc % ready_period) == 0);
        for (int i = 0; i < 4; i++) begin
            h = qhead(i);
            req_valid[i]       = (qsize(i) != 0);
            req_data[i*8 +: 8] = h[7:0];
            req_last[i]        = h[8];
        end
    endtask

    // One clock: observe at negedge, advance, then apply new stimulus.
    task automatic tick();
        logic [3:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (timeout) begin
            to_cnt++;
            to_edge = cyc - base;
        end
        if (busy && ((req_ready & ~(4'b0001 << grant_id)) != 4'b0000)) stray++;
        if (tx_valid && tx_ready) begin
            wire_q.push_back(tx_data);
            gid_q.push_back(grant_id);
            edge_q.push_back(cyc + 1 - base);
            $display("tx byte=%02h id=%0d edge=%0d", tx_data, grant_id, cyc + 1 - base);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) qpop(i);
        end
        drive();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        wire_q.delete(); gid_q.delete(); edge_q.delete();
        to_cnt = 0; to_edge = -1; stray = 0; ready_period = 0;
        drive();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        base = cyc;
        drive();
    endtask

    task automatic expect_byte(string tag, int idx, logic [7:0] d, logic [1:0] g, int e);
        check({tag, "_data"}, (idx < wire_q.size()) ? 32'(wire_q[idx]) : 32'hFFFF_FFFF, 32'(d));
        check({tag, "_gid"},  (idx < gid_q.size())  ? 32'(gid_q[idx])  : 32'hFFFF_FFFF, 32'(g));
        if (e >= 0)
            check({tag, "_edge"}, (idx < edge_q.size()) ? 32'(edge_q[idx]) : 32'hFFFF_FFFF, 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, checked before any clock edge with requests pending.
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hA5A5_A5A5;
        req_last  = 4'hF;
        tx_ready  = 1'b1;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_tx_valid",  32'(tx_valid),  32'h0);
        check("rst_tx_data",   32'(tx_data),   32'h0);
        check("rst_grant_id",  32'(grant_id),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_timeout",   32'(timeout),   32'h0);

        // Single requester, tx_ready pulsed every 10 cycles.
        reset_dut();
        ready_period = 10;
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
        start();
        for (int k = 0; k < 200 && wire_q.size() < 3; k++) tick();
        check("t1_count", 32'(wire_q.size()), 32'd3);
        expect_byte("t1_b0", 0, 8'h41, 2'd0, -1);
        expect_byte("t1_b1", 1, 8'h42, 2'd0, -1);
        expect_byte("t1_b2", 2, 8'h43, 2'd0, -1);
        check("t1_busy_after",  32'(busy),     32'h0);
        check("t1_txv_after",   32'(tx_valid), 32'h0);
        check("t1_txd_after",   32'(tx_data),  32'h0);

        // Three simultaneous 2-byte messages, no interleaving.
        reset_dut();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
        push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
        push(2, 8'h30, 1'b0); push(2, 8'h31, 1'b1);
        start();
        repeat (12) tick();
        check("t2_count", 32'(wire_q.size()), 32'd6);
        expect_byte("t2_b0", 0, 8'h10, 2'd0, 2);
        expect_byte("t2_b1", 1, 8'h11, 2'd0, 3);
        expect_byte("t2_b2", 2, 8'h20, 2'd1, 5);
        expect_byte("t2_b3", 3, 8'h21, 2'd1, 6);
        expect_byte("t2_b4", 4, 8'h30, 2'd2, 8);
        expect_byte("t2_b5", 5, 8'h31, 2'd2, 9);
        check("t2_stray_ready", 32'(stray), 32'd0);
        check("t2_busy_after",  32'(busy),  32'h0);

        // Fairness: 0 re-requests at once, 3 keeps waiting.
        reset_dut();
        push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1);
        push(3, 8'hD0, 1'b1); push(3, 8'hD1, 1'b1);
        start();
        repeat (10) tick();
        check("t3_count", 32'(wire_q.size()), 32'd4);
        expect_byte("t3_b0", 0, 8'hA0, 2'd0, 2);
        expect_byte("t3_b1", 1, 8'hD0, 2'd3, 4);
        expect_byte("t3_b2", 2, 8'hA1, 2'd0, 6);
        expect_byte("t3_b3", 3, 8'hD1, 2'd3, 8);

        // Stall: requester 1 goes quiet mid-message, 2 is waiting.
        reset_dut();
        push(1, 8'h55, 1'b0);
        push(2, 8'h66, 1'b1);
        start();
        repeat (10) tick();
        check("t4_mid_busy",     32'(busy),      32'h1);
        check("t4_mid_gid",      32'(grant_id),  32'd1);
        check("t4_mid_txv",      32'(tx_valid),  32'h0);
        check("t4_mid_ready",    32'(req_ready), 32'h0);
        check("t4_mid_timeout",  32'(to_cnt),    32'd0);
        repeat (12) tick();
        check("t4_timeout_cnt",  32'(to_cnt),    32'd1);
        check("t4_timeout_edge", 32'(to_edge),   32'd18);
        check("t4_count", 32'(wire_q.size()), 32'd2);
        expect_byte("t4_b0", 0, 8'h55, 2'd1, 2);
        expect_byte("t4_b1", 1, 8'h66, 2'd2, 20);
        check("t4_stray_ready",  32'(stray),     32'd0);

        // Last byte lands exactly when the timeout would fire.
        reset_dut();
        push(1, 8'h77, 1'b0);
        start();
        repeat (17) tick();
        push(1, 8'h78, 1'b1);
        drive();
        repeat (4) tick();
        check("t5_timeout_cnt", 32'(to_cnt), 32'd0);
        check("t5_count", 32'(wire_q.size()), 32'd2);
        expect_byte("t5_b0", 0, 8'h77, 2'd1, 2);
        expect_byte("t5_b1", 1, 8'h78, 2'd1, 18);
        check("t5_busy_after",  32'(busy),   32'h0);

        // Asynchronous reset while requester 3 owns the grant.
        reset_dut();
        ready_period = 10;
        push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b0); push(3, 8'h33, 1'b1);
        start();
        for (int k = 0; k < 50 && wire_q.size() < 1; k++) tick();
        tx_ready = 1'b1;
        #1;
        check("t6_pre_busy",  32'(busy),      32'h1);
        check("t6_pre_gid",   32'(grant_id),  32'd3);
        check("t6_pre_txv",   32'(tx_valid),  32'h1);
        check("t6_pre_txd",   32'(tx_data),   32'h32);
        check("t6_pre_ready", 32'(req_ready), 32'h8);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_txv",   32'(tx_valid),  32'h0);
        check("t6_rst_ready", 32'(req_ready), 32'h0);
        check("t6_rst_busy",  32'(busy),      32'h0);
        check("t6_rst_gid",   32'(grant_id),  32'd0);
        check("t6_rst_txd",   32'(tx_data),   32'h0);
        reset_dut();
        push(3, 8'hE3, 1'b1);
        push(0, 8'hE0, 1'b1);
        start();
        repeat (6) tick();
        check("t6_count", 32'(wire_q.size()), 32'd2);
        expect_byte("t6_b0", 0, 8'hE0, 2'd0, 2);
        expect_byte("t6_b1", 1, 8'hE3, 2'd3, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_tx` transmitter between several byte-stream requesters, e.g. the echo path from `arduino_uart_buffer`, a status reporter and a debug source. It sits between the requesters and `uart_tx`. It speaks the same valid/ready handshake on both sides. Grant is held for a whole multi-byte message, delimited by a `last` flag, so messages from different sources never interleave on the wire. An idle-timeout releases a requester that stalls mid-message.

## Interface
- `N_REQ`, default 4: number of requesters, range 1..8.
- `DATA_WIDTH`, default 8: byte width, matching `uart_tx` `data_tx`.
- `TIMEOUT_CYCLES`, default 5_000_000: consecutive owner-idle cycles before a forced release (100 ms at 50 MHz).
- `clk` in 1: system clock (CLOCK_50).
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in N_REQ*DATA_WIDTH: per-requester byte. Requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` in N_REQ: marks the final byte of a message.
- `req_ready` out N_REQ: per-requester byte accepted.
- `tx_data` out DATA_WIDTH: to `uart_tx.data_tx`.
- `tx_valid` out 1: to `uart_tx.valid`.
- `tx_ready` in 1: from `uart_tx.ready`.
- `grant_id` out $clog2(N_REQ) (min 1): current or most recent owner index.
- `busy` out 1: a message is in progress.
- `timeout` out 1: one-cycle pulse on a forced release.

## Operation
- Handshake: a byte transfers on any cycle where `tx_valid && tx_ready`. Requesters must hold `req_valid` and `req_data`/`req_last` stable until `req_ready`. The arbiter does not buffer data.
- FSM states: IDLE, GRANT.
  - IDLE: `busy` is 0. All `req_ready` and `tx_valid` are 0. If any `req_valid` is high, pick the first asserted index searching upward from `rr_ptr` with wrap-around. Register it as `owner`/`grant_id` and go to GRANT.
  - GRANT: `busy` is 1. `tx_valid = req_valid[owner]` and `tx_data = req_data[owner]`, both combinational passthrough. `req_ready[owner] = tx_ready & req_valid[owner]`. All other `req_ready` are 0.
  - Handshake with `req_last[owner]=1`: go to IDLE and set `rr_ptr <= (owner+1) mod N_REQ`.
  - Handshake with `last=0`: stay in GRANT.
- Timeout counter:
  - Cleared on entry to GRANT and on every handshake.
  - Increments each GRANT cycle where `req_valid[owner]=0`. Saturates; no wrap.
  - Reaching TIMEOUT_CYCLES-1 with valid still low: go to IDLE, pulse `timeout` for 1 cycle, set `rr_ptr <= owner+1`.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Non-owner requests are ignored until the owner releases. Their `req_ready` stays 0.

## Timing
- Reset values: `req_ready`=0, `tx_valid`=0, `tx_data`=0, `grant_id`=0, `busy`=0, `timeout`=0, `rr_ptr`=0, counter=0, state IDLE.
- Arbitration latency: `req_valid` seen high in IDLE at edge k gives GRANT at k+1. `tx_valid` can rise in the cycle after that edge, so there is a one-cycle bubble per message.
- Back-to-back: after a `last` handshake at edge k, IDLE at k+1 and the next grant at k+2. There is at most one idle cycle on the `tx_valid` side between messages.
- Within a message: zero added latency. Throughput is limited only by `uart_tx`.
- Owner deasserts `req_valid` mid-message: `tx_valid` drops the same cycle. The grant is held until timeout.
- `tx_ready` high while owner valid is low: no transfer, no state change besides the counter.
- `last` and timeout coincide: the handshake wins. The release is normal and `timeout` stays 0.
- Reset asserted mid-message: all outputs go to reset values immediately, asynchronously.
  - The partially sent message is abandoned; `uart_tx` completes any byte already accepted on its own.
  - After `rst_n` rises, the first arbitration starts from index 0.
- N_REQ=1: the pick is always 0 and the FSM behaves identically.

## Test plan
- Single requester 0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), with `tx_ready` pulsed every 10 cycles -> `tx_data` sequence is exactly 41, 42, 43. `busy` falls the cycle after the 0x43 handshake. `grant_id`=0.
- Requesters 0, 1, 2 assert simultaneously, each with a 2-byte message (0x10/0x11, 0x20/0x21, 0x30/0x31) -> wire order 10, 11, 20, 21, 30, 31 with no interleaving. `grant_id` sequence is 0, 1, 2.
- Fairness: requester 0 re-requests immediately after each message while 3 is also waiting -> grants alternate 0, 3, 0, 3.
- Stall: requester 1 sends byte 0x55 with last=0, then drops valid. TIMEOUT_CYCLES=16 for the test -> `timeout` pulses exactly once, 16 idle cycles after the handshake, then the pending requester 2 is granted.
- Coincidence: the last byte handshakes on the same cycle the timeout would fire -> `timeout` stays 0 and the release is normal.
- Reset: assert `rst_n`=0 mid-message while requester 3 owns the grant -> `tx_valid`, `req_ready` and `busy` go to 0 without waiting for a clock edge. After release, simultaneous requests from 3 and 0 grant 0 first.
